bram_mp_pipe: RTL and testbench

//  Parametrised multi-read-port block RAM for the convolution datapath: one write port and RAM_PORTS

---
 rtl/bram_pkg.sv | 23 ++
 rtl/bram_rd_pipe.sv | 44 ++++
 rtl/bram_mp_pipe.sv | 124 ++++++++++++
 tb/tb_bram_mp_pipe.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bram_pkg.sv
// Shared constants for the multi-port block RAM: read-during-write policies,
// sequencer state encodings and a width helper usable in parameter defaults.
package bram_pkg;

    localparam int RDW_READ_FIRST  = 0;
    localparam int RDW_WRITE_FIRST = 1;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    // Never returns less than 1 so a single-word array still gets a usable index.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((longint'(1) << i) < longint'(value)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Per-port read pipeline: LATENCY stages of {valid, data}; each data stage only
// loads behind a valid bit, so the output word holds between pulses.
module bram_rd_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data
);

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [WIDTH-1:0]   dat_q [LATENCY];
    logic [WIDTH-1:0]   dat_d [LATENCY];

    always_comb begin
        vld_d[0] = i_valid;
        dat_d[0] = i_valid ? i_data : dat_q[0];
        for (int i = 1; i < LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = vld_q[i-1] ? dat_q[i-1] : dat_q[i];
        end
    end

    // Data stages are cleared along with the valid bits so o_data reads 0 in reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
            end
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign o_valid = vld_q[LATENCY-1];
    assign o_data  = dat_q[LATENCY-1];

endmodule

// File: rtl/bram_mp_pipe.sv
// Multi-read-port block RAM with configurable read latency, read-during-write
// policy and a word-per-cycle clear sequencer gating all port activity.
module bram_mp_pipe
    import bram_pkg::*;
#(
    parameter int RAM_WIDTH      = 8,
    parameter int RAM_DEPTH      = (252**2)*2,
    parameter int ADDR_WIDTH     = clog2(RAM_DEPTH),
    parameter int RAM_PORTS      = 2,
    parameter int RD_LATENCY     = 1,
    parameter int RDW_MODE       = RDW_READ_FIRST,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                            i_clk,
    input  logic                            i_rst_n,
    input  logic                            i_clear,
    input  logic                            i_wr_en,
    input  logic [ADDR_WIDTH-1:0]           i_w_addrs,
    input  logic [RAM_WIDTH-1:0]            i_data,
    input  logic [RAM_PORTS-1:0]            i_r_en,
    input  logic [ADDR_WIDTH*RAM_PORTS-1:0] i_r_addrs,
    output logic [RAM_WIDTH*RAM_PORTS-1:0]  o_data,
    output logic [RAM_PORTS-1:0]            o_valid,
    output logic                            o_ready
);

    localparam int                IDX_W     = clog2(RAM_DEPTH);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH+1)'(RAM_DEPTH);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(RAM_DEPTH - 1);
    localparam logic [0:0]        RST_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

    logic [RAM_WIDTH-1:0] mem_q [RAM_DEPTH];
    logic [0:0]           state_q, state_d;
    logic [IDX_W-1:0]     cnt_q, cnt_d;
    logic                 ready;
    logic                 clearing;
    logic                 wr_acc;
    logic                 mem_we;
    logic [IDX_W-1:0]     mem_wa;
    logic [RAM_WIDTH-1:0] mem_wd;

    assign ready    = (state_q == ST_READY);
    assign clearing = (state_q == ST_CLEAR);
    assign wr_acc   = ready && i_wr_en && ({1'b0, i_w_addrs} < DEPTH_X);
    assign o_ready  = ready;

    always_comb begin
        // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_CLEAR: begin
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_READY: begin
                if (i_clear) begin
                    state_d = ST_CLEAR;
                end
            end
            default: state_d = RST_STATE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= RST_STATE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The clear sequencer owns the single write port while it runs.
    always_comb begin
        mem_we = clearing || wr_acc;
        mem_wa = clearing ? cnt_q : i_w_addrs[IDX_W-1:0];
        mem_wd = clearing ? '0 : i_data;
    end

    // NOTE: the array has no reset so it maps onto block RAM; zeroing is the sequencer's job.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    for (genvar k = 0; k < RAM_PORTS; k++) begin : g_port
        logic [ADDR_WIDTH-1:0] r_addr;
        logic                  r_acc;
        logic [RAM_WIDTH-1:0]  r_word;

        assign r_addr = i_r_addrs[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign r_acc  = ready && i_r_en[k];

        always_comb begin
            r_word = '0;
            if ((RDW_MODE == RDW_WRITE_FIRST) && wr_acc && (i_w_addrs == r_addr)) begin
                r_word = i_data;
            end else if ({1'b0, r_addr} < DEPTH_X) begin
                r_word = mem_q[r_addr[IDX_W-1:0]];
            end
        end

        bram_rd_pipe #(
            .WIDTH   (RAM_WIDTH),
            .LATENCY (RD_LATENCY)
        ) u_rd_pipe (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_valid (r_acc),
            .i_data  (r_word),
            .o_valid (o_valid[k]),
            .o_data  (o_data[k*RAM_WIDTH +: RAM_WIDTH])
        );
    end

endmodule

// File: tb/tb_bram_mp_pipe.sv
// Scoreboard bench: two instances (read-first/latency 2, write-first/latency 1)
// share stimulus; a word-level reference model predicts every read response.
module tb_bram_mp_pipe;

    localparam int DEPTH = 16;
    localparam int AW    = 5;
    localparam int W     = 8;
    localparam int P     = 2;

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           i_clear;
    logic           i_wr_en;
    logic [AW-1:0]  i_w_addrs;
    logic [W-1:0]   i_data;
    logic [P-1:0]   i_r_en;
    logic [AW*P-1:0] i_r_addrs;
    logic [W*P-1:0] oa_data, ob_data;
    logic [P-1:0]   oa_valid, ob_valid;
    logic           oa_ready, ob_ready;

    exp_t         sb [2][P][$];
    logic [W-1:0] mem_m [DEPTH];
    logic [W-1:0] last_d [2][P];
    int           busy = DEPTH;
    int           cyc = 0;
    int           n_checks = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    bram_mp_pipe #(
        .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RAM_PORTS(P),
        .RD_LATENCY(2), .RDW_MODE(0), .CLEAR_ON_RESET(1)
    ) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_wr_en(i_wr_en),
        .i_w_addrs(i_w_addrs), .i_data(i_data), .i_r_en(i_r_en), .i_r_addrs(i_r_addrs),
        .o_data(oa_data), .o_valid(oa_valid), .o_ready(oa_ready)
    );

    bram_mp_pipe #(
        .RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .ADDR_WIDTH(AW), .RAM_PORTS(P),
        .RD_LATENCY(1), .RDW_MODE(1), .CLEAR_ON_RESET(1)
    ) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(i_clear), .i_wr_en(i_wr_en),
        .i_w_addrs(i_w_addrs), .i_data(i_data), .i_r_en(i_r_en), .i_r_addrs(i_r_addrs),
        .o_data(ob_data), .o_valid(ob_valid), .o_ready(ob_ready)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a clear wipes the array at once and then blocks the
    // ports for DEPTH edges; reads see the array as it was before the edge.
    always @(posedge clk or negedge rst_n) begin
        int           a;
        logic [W-1:0] old_w, new_w;
        if (!rst_n) begin
            busy = DEPTH;
            for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
        end else begin
            cyc++;
            if (busy > 0) begin
                busy--;
            end else begin
                for (int k = 0; k < P; k++) begin
                    if (i_r_en[k]) begin
                        a = int'(i_r_addrs[k*AW +: AW]);
                        old_w = (a < DEPTH) ? mem_m[a[3:0]] : '0;
                        new_w = (i_wr_en && int'(i_w_addrs) == a && a < DEPTH) ? i_data : old_w;
                        sb[0][k].push_back('{old_w, cyc + 1});
                        sb[1][k].push_back('{new_w, cyc});
                    end
                end
                if (i_wr_en && int'(i_w_addrs) < DEPTH) mem_m[i_w_addrs[3:0]] = i_data;
                if (i_clear) begin
                    busy = DEPTH;
                    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
                end
            end
        end
    end

    // Monitor: compares every presented output against the scoreboard.
    always @(negedge clk) begin
        logic         v;
        logic [W-1:0] d;
        exp_t         e;
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < P; k++) begin
                    sb[i][k].delete();
                    last_d[i][k] = '0;
                end
            end
            check("reset_outputs", {oa_ready, ob_ready, oa_valid, ob_valid, oa_data, ob_data}, 64'd0);
        end else begin
            check("ready_a", oa_ready, busy == 0);
            check("ready_b", ob_ready, busy == 0);
            for (int i = 0; i < 2; i++) begin
                for (int k = 0; k < P; k++) begin
                    v = (i == 0) ? oa_valid[k] : ob_valid[k];
                    d = (i == 0) ? oa_data[k*W +: W] : ob_data[k*W +: W];
                    if (v) begin
                        if (sb[i][k].size() == 0) begin
                            check($sformatf("dut%0d_p%0d spurious_valid", i, k), v, 1'b0);
                        end else begin
                            e = sb[i][k].pop_front();
                            check($sformatf("dut%0d_p%0d rd_data", i, k), d, e.data);
                            check($sformatf("dut%0d_p%0d rd_cycle", i, k), cyc, e.due);
                            last_d[i][k] = e.data;
                        end
                    end else begin
                        check($sformatf("dut%0d_p%0d hold_data", i, k), d, last_d[i][k]);
                        if (sb[i][k].size() > 0 && sb[i][k][0].due <= cyc) begin
                            check($sformatf("dut%0d_p%0d missing_valid", i, k), v, 1'b1);
                            void'(sb[i][k].pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [W-1:0] wd,
                         input logic [P-1:0] re, input logic [AW-1:0] ra0,
                         input logic [AW-1:0] ra1, input logic clr);
        i_wr_en   = we;
        i_w_addrs = wa;
        i_data    = wd;
        i_r_en    = re;
        i_r_addrs = {ra1, ra0};
        i_clear   = clr;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, '0, '0, '0, '0, 1'b0);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!(oa_ready && ob_ready) && n < 64) begin
            idle(1);
            n++;
        end
        check("ready_timeout", oa_ready && ob_ready, 1'b1);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) drive(1'b0, '0, '0, 2'b11, AW'(a), AW'(DEPTH - 1 - a), 1'b0);
        idle(3);
    endtask

    task automatic pulse_reset();
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", {oa_ready, ob_ready, oa_valid, ob_valid, oa_data, ob_data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        i_clear = 1'b0; i_wr_en = 1'b0; i_w_addrs = '0; i_data = '0; i_r_en = '0; i_r_addrs = '0;
        #1 check("reset_state", {oa_ready, ob_ready, oa_valid, ob_valid, oa_data, ob_data}, 64'd0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        wait_ready();
        read_all();

        drive(1'b1, 5'd3, 8'hA5, 2'b00, '0, '0, 1'b0);
        idle(1);
        drive(1'b0, '0, '0, 2'b10, '0, 5'd3, 1'b0);
        idle(3);

        drive(1'b1, 5'd5, 8'h11, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd5, 8'h3C, 2'b11, 5'd5, 5'd5, 1'b0);
        idle(3);

        drive(1'b1, 5'd20, 8'h77, 2'b11, 5'd20, 5'd20, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 5'd20, 5'd4, 1'b0);
        read_all();

        for (int a = 0; a < DEPTH; a++) drive(1'b1, AW'(a), 8'hFF, 2'b00, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, AW'($urandom_range(0, DEPTH - 1)), W'($urandom), 2'b11,
                  AW'($urandom_range(0, DEPTH - 1)), AW'($urandom_range(0, DEPTH - 1)), 1'b1);
        end
        idle(1);
        wait_ready();
        read_all();

        drive(1'b1, 5'd9, 8'h5A, 2'b00, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 2'b11, 5'd9, 5'd2, 1'b0);
        pulse_reset();
        wait_ready();

        drive(1'b1, 5'd7, 8'h42, 2'b00, '0, '0, 1'b0);
        drive(1'b0, '0, '0, 2'b00, '0, '0, 1'b1);
        idle(7);
        pulse_reset();
        wait_ready();
        read_all();

        for (int i = 0; i < 400; i++) begin
            logic [AW-1:0] wa;
            wa = AW'($urandom_range(0, 19));
            drive(1'b1 & $urandom_range(0, 1), wa, W'($urandom), P'($urandom),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 19)),
                  ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 19)),
                  $urandom_range(0, 99) == 0);
        end
        idle(4);
        wait_ready();
        read_all();

        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < P; k++) begin
                check($sformatf("dut%0d_p%0d scoreboard_empty", i, k), sb[i][k].size(), 0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200us;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
